// File: rtl/mole_spawner.sv
// mole_spawner: whack-a-mole game controller feeding the 16-hole mole renderer.
// Picks a pseudo-random hole for each mole, judges keypad hits, and tracks score/misses.
// Optional: define MOLE_SPEEDUP_EN to shorten the up window by one tick per 8 hits (min 1).
module mole_spawner #(
    parameter int          TICK_DIV  = 25000000,
    parameter int          UP_TICKS  = 3,
    parameter int          GAP_TICKS = 1,
    parameter int          MAX_MISS  = 5,
    parameter int          SCORE_W   = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               key_en,
    input  logic [3:0]         key_index,
    output logic               mole_appear,
    output logic [3:0]         mole_index,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         misses,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               game_over
);

    localparam int TW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PH_MAX = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GAP  = 2'd1;
    localparam logic [1:0] ST_UP   = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [TW-1:0]   tick_cnt;
    logic [PH_W-1:0] phase_cnt;
    logic [PH_W-1:0] up_last;
    logic [15:0]     lfsr;
    logic            tick;
    logic            is_hit;
    logic            is_timeout;
    logic            spawn;
    logic            transition;
    logic [3:0]      misses_inc;
    logic [3:0]      spawn_index;

    assign tick        = (tick_cnt == TW'(TICK_DIV - 1));
    assign is_hit      = key_en && (key_index == mole_index);
    assign is_timeout  = tick && (phase_cnt == up_last);
    assign misses_inc  = misses + 4'd1;
    // Bump to the neighbouring hole so the same hole never appears twice in a row
    assign spawn_index = (lfsr[3:0] == mole_index) ? lfsr[3:0] + 4'd1 : lfsr[3:0];
    assign spawn       = (state == ST_GAP) && (state_nxt == ST_UP) && !start;
    // A start pulse counts as a transition even when already in GAP
    assign transition  = start || (state_nxt != state);

    assign mole_appear = (state == ST_UP);
    assign game_over   = (state == ST_OVER);

`ifdef MOLE_SPEEDUP_EN
    logic [SCORE_W-1:0] score_div8;
    logic [PH_W-1:0]    up_last_nxt;

    assign score_div8 = score >> 3;

    // Up window shrinks one tick per 8 hits, never below one tick
    always_comb begin
        up_last_nxt = '0;
        if (32'(score_div8) < 32'(UP_TICKS)) begin
            up_last_nxt = PH_W'(32'(UP_TICKS - 1) - 32'(score_div8));
        end
    end

    // Window latched on entry to UP so a hit mid-window cannot change it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_last <= PH_W'(UP_TICKS - 1);
        end else if (spawn) begin
            up_last <= up_last_nxt;
        end
    end
`else
    assign up_last = PH_W'(UP_TICKS - 1);
`endif

    // Next game state; start overrides everything, a hit beats a timeout
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_GAP;
        end else begin
            case (state)
                ST_GAP: begin
                    if (tick && (phase_cnt == PH_W'(GAP_TICKS - 1))) begin
                        state_nxt = ST_UP;
                    end
                end
                ST_UP: begin
                    if (is_hit) begin
                        state_nxt = ST_GAP;
                    end else if (is_timeout) begin
                        state_nxt = (misses_inc == 4'(MAX_MISS)) ? ST_OVER : ST_GAP;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // State, timers, LFSR, scoring and one-cycle event pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            phase_cnt  <= '0;
            lfsr       <= LFSR_SEED;
            mole_index <= 4'd0;
            score      <= '0;
            misses     <= 4'd0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            state      <= state_nxt;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;

            if (transition) begin
                tick_cnt  <= '0;
                phase_cnt <= '0;
            end else if ((state == ST_GAP) || (state == ST_UP)) begin
                if (tick) begin
                    tick_cnt  <= '0;
                    phase_cnt <= phase_cnt + 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end

            if (start) begin
                score  <= '0;
                misses <= 4'd0;
            end else if (spawn) begin
                mole_index <= spawn_index;
            end else if (state == ST_UP) begin
                if (is_hit) begin
                    if (score != '1) begin
                        score <= score + 1'b1;
                    end
                    hit_pulse <= 1'b1;
                end else if (is_timeout) begin
                    misses     <= misses_inc;
                    miss_pulse <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mole_spawner.sv
// Self-checking bench for mole_spawner: directed game scenarios plus randomized play,
// compared every cycle against a countdown-based game model.
module tb_mole_spawner;

    localparam int TD = 4;
    localparam int UPT = 3;
    localparam int GPT = 1;
    localparam int MM = 3;
    localparam int SW = 8;
    localparam int SMAX = (1 << SW) - 1;

    localparam int M_IDLE = 0;
    localparam int M_GAP = 1;
    localparam int M_UP = 2;
    localparam int M_OVER = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          key_en = 1'b0;
    logic [3:0]    key_index = 4'd0;
    logic          mole_appear;
    logic [3:0]    mole_index;
    logic [SW-1:0] score;
    logic [3:0]    misses;
    logic          hit_pulse;
    logic          miss_pulse;
    logic          game_over;

    mole_spawner #(
        .TICK_DIV (TD),
        .UP_TICKS (UPT),
        .GAP_TICKS(GPT),
        .MAX_MISS (MM),
        .SCORE_W  (SW),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_en     (key_en),
        .key_index  (key_index),
        .mole_appear(mole_appear),
        .mole_index (mole_index),
        .score      (score),
        .misses     (misses),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: game phase plus cycles remaining in it
    int          m_state;
    int          m_left;
    int          m_score;
    int          m_miss;
    int          m_hit;
    int          m_mp;
    logic [3:0]  m_idx;
    logic [15:0] m_lfsr;

    logic       chk_en = 1'b0;
    logic       prev_appear = 1'b0;
    logic [3:0] last_spawn = 4'd0;
    int         spawns = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic int up_cycles(input int sc);
        int w;
        w = UPT;
`ifdef MOLE_SPEEDUP_EN
        w = UPT - sc / 8;
        if (w < 1) w = 1;
`endif
        return w * TD;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_left = 0;
        m_score = 0;
        m_miss = 0;
        m_hit = 0;
        m_mp = 0;
        m_idx = 4'd0;
        m_lfsr = 16'hACE1;
    endtask

    task automatic model_step();
        logic [15:0] cur;
        logic [3:0]  cand;
        cur = m_lfsr;
        m_lfsr = lfsr_next(m_lfsr);
        m_hit = 0;
        m_mp = 0;
        if (start) begin
            m_score = 0;
            m_miss = 0;
            m_state = M_GAP;
            m_left = GPT * TD;
        end else if (m_state == M_GAP) begin
            m_left--;
            if (m_left == 0) begin
                cand = cur[3:0];
                if (cand == m_idx) cand = cand + 4'd1;
                m_idx = cand;
                m_state = M_UP;
                m_left = up_cycles(m_score);
            end
        end else if (m_state == M_UP) begin
            if (key_en && key_index == m_idx) begin
                if (m_score < SMAX) m_score++;
                m_hit = 1;
                m_state = M_GAP;
                m_left = GPT * TD;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_miss++;
                    m_mp = 1;
                    m_state = (m_miss == MM) ? M_OVER : M_GAP;
                    m_left = GPT * TD;
                end
            end
        end
    endtask

    // One clock edge: advance the model with the inputs the DUT samples, then drive new inputs
    task automatic step(input logic st, input logic ke, input logic [3:0] ki);
        @(posedge clk);
        if (!rst) model_step();
        #1;
        start = st;
        key_en = ke;
        key_index = ki;
    endtask

    task automatic apply_reset(input int n);
        @(posedge clk);
        model_step();
        #1;
        rst = 1'b1;
        start = 1'b0;
        key_en = 1'b0;
        model_reset();
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    // Steps idle until a mole is up; returns number of edges taken
    task automatic wait_appear(input int limit, output int n);
        n = 0;
        while (!mole_appear && n < limit) begin
            step(1'b0, 1'b0, 4'd0);
            n++;
        end
        if (!mole_appear) check("wait_appear_timeout", 0, 1);
    endtask

    // Compare DUT against the model every cycle, and police the no-repeat rule
    always @(negedge clk) begin
        if (chk_en) begin
            check("mole_appear", int'(mole_appear), int'(m_state == M_UP));
            check("game_over", int'(game_over), int'(m_state == M_OVER));
            check("score", int'(score), m_score);
            check("misses", int'(misses), m_miss);
            check("hit_pulse", int'(hit_pulse), m_hit);
            check("miss_pulse", int'(miss_pulse), m_mp);
            check("mole_index", int'(mole_index), int'(m_idx));
            if (rst) begin
                last_spawn = 4'd0;
                prev_appear = 1'b0;
            end else begin
                if (mole_appear && !prev_appear) begin
                    spawns++;
                    check("index_repeat", int'(mole_index != last_spawn), 1);
                    last_spawn = mole_index;
                end
                prev_appear = mole_appear;
            end
        end
    end

    initial begin
        int n;
        int m;
        int cyc;
        int kp;
        logic       st;
        logic       ke;
        logic [3:0] ki;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst = 1'b0;

        // Idle without start: everything stays low
        repeat (100) step(1'b0, 1'b0, 4'd0);
        check("idle_appear", int'(mole_appear), 0);
        check("idle_score", int'(score), 0);
        check("idle_misses", int'(misses), 0);
        check("idle_over", int'(game_over), 0);

        // Start: mole 4 cycles after the start edge, up for 12 cycles, then a miss
        step(1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0);
        wait_appear(20, n);
        check("spawn_latency", n, 4);
        m = 0;
        while (mole_appear && m < 30) begin
            step(1'b0, 1'b0, 4'd0);
            m++;
        end
        check("up_window", m, 12);
        check("first_miss_pulse", int'(miss_pulse), 1);
        check("first_misses", int'(misses), 1);

        // Wrong key is ignored, right key scores
        wait_appear(20, n);
        step(1'b0, 1'b1, mole_index + 4'd1);
        step(1'b0, 1'b0, 4'd0);
        check("wrong_key_up", int'(mole_appear), 1);
        check("wrong_key_score", int'(score), 0);
        step(1'b0, 1'b1, mole_index);
        step(1'b0, 1'b0, 4'd0);
        check("hit_pulse_lit", int'(hit_pulse), 1);
        check("hit_score_lit", int'(score), 1);
        check("hit_drop_lit", int'(mole_appear), 0);

        // Let moles time out until the game ends
        n = 0;
        while (!game_over && n < 200) begin
            step(1'b0, 1'b0, 4'd0);
            n++;
        end
        check("over_reached", int'(game_over), 1);
        check("over_misses", int'(misses), 3);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 4'd0);
            check("over_no_mole", int'(mole_appear), 0);
        end
        check("over_score_hold", int'(score), 1);

        // Restart from OVER
        step(1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0);
        check("restart_score", int'(score), 0);
        check("restart_misses", int'(misses), 0);
        check("restart_over", int'(game_over), 0);
        wait_appear(20, n);
        check("restart_latency", n, 4);

        // Hit landing on the timeout edge counts as a hit only
        repeat (10) step(1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, mole_index);
        step(1'b0, 1'b0, 4'd0);
        check("edge_hit_pulse", int'(hit_pulse), 1);
        check("edge_hit_score", int'(score), 1);
        check("edge_no_miss_pulse", int'(miss_pulse), 0);
        check("edge_misses", int'(misses), 0);

        // Randomized play with restarts, mid-game resets and varying key rates
        cyc = 0;
        while ((spawns < 220 || cyc < 3000) && cyc < 30000) begin
            kp = ((cyc / 1000) % 2 == 0) ? 50 : 10;
            if ($urandom_range(0, 2499) == 0) begin
                apply_reset(2);
            end else begin
                st = ($urandom_range(0, 999) == 0) || (game_over && $urandom_range(0, 7) == 0);
                ke = ($urandom_range(0, 99) < kp);
                ki = ($urandom_range(0, 3) != 0) ? mole_index : 4'($urandom_range(0, 15));
                step(st, ke, ki);
            end
            cyc++;
        end
        check("spawn_count", int'(spawns >= 200), 1);

        step(1'b0, 1'b0, 4'd0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
